// File: rtl/timer_dev.sv
// timer_dev: a programmable down-counting timer with a small register file.
// It has three registers: CTRL, PRESET and COUNT.
// A four-state FSM reloads COUNT from PRESET, counts down to zero and then
// raises IntFlag. IRQ is IntFlag gated by the interrupt mask bit in CTRL.
module timer_dev #(
  parameter logic [31:0] PRESET_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:2]  Addr,
  input  logic        We,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL    = 2'd0;
  localparam logic [1:0] A_PRESET  = 2'd1;
  localparam logic [1:0] A_COUNT   = 2'd2;
  localparam logic [1:0] MODE_AUTO = 2'b01;

  // CTRL fields: [0] En, [2:1] Mode, [3] IM
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_int_flag;
  state_t      r_state;

  state_t      w_state_nxt;
  logic [31:0] w_count_nxt;
  logic        w_en;
  logic        w_im;
  logic        w_auto;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_expire;

  assign w_en        = r_ctrl[0];
  assign w_im        = r_ctrl[3];
  // Only Mode 1 reloads automatically; Modes 0, 2 and 3 are one-shot.
  assign w_auto      = (r_ctrl[2:1] == MODE_AUTO);
  assign w_wr_ctrl   = We && (Addr == A_CTRL);
  assign w_wr_preset = We && (Addr == A_PRESET);
  assign w_expire    = (r_state == S_INT);

  // Next-state and next-COUNT logic for the IDLE/LOAD/CNT/INT sequence
  always_comb begin
    // NOTE: every output of this block is given a default first, so a
    // branch that forgets an assignment cannot infer a latch.
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    unique case (r_state)
      S_IDLE: begin
        if (w_en) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!w_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_count <= 32'd1) begin
          // A PRESET of 0 lands here too, so it expires like a PRESET of 1.
          w_count_nxt = 32'd0;
          w_state_nxt = S_INT;
        end else begin
          w_count_nxt = r_count - 32'd1;
        end
      end
      S_INT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state and COUNT registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= 32'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the pre-edge values of its inputs.
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // CTRL register: a software write wins over the one-shot En clear at expiry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl <= 4'd0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= DIn[3:0];
    end else if (w_expire && !w_auto) begin
      r_ctrl[0] <= 1'b0;
    end
  end

  // PRESET register; a running count only picks up a new value at its next LOAD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_preset <= PRESET_INIT;
    end else if (w_wr_preset) begin
      r_preset <= DIn;
    end
  end

  // IntFlag: cleared by register writes (highest priority), set at expiry,
  // and self-clearing after one cycle in auto-reload mode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_int_flag <= 1'b0;
    end else if (w_wr_ctrl || w_wr_preset) begin
      r_int_flag <= 1'b0;
    end else if (w_expire) begin
      r_int_flag <= 1'b1;
    end else if (r_int_flag && w_auto) begin
      r_int_flag <= 1'b0;
    end
  end

  // Combinational read mux; COUNT is read-only and Addr 3 reads as zero
  always_comb begin
    DOut = 32'd0;
    unique case (Addr)
      A_CTRL:   DOut = {28'd0, r_ctrl};
      A_PRESET: DOut = r_preset;
      A_COUNT:  DOut = r_count;
      default:  DOut = 32'd0;
    endcase
  end

  // IRQ is not registered, so an asynchronous reset drops it immediately
  assign IRQ = r_int_flag & w_im;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev.
// It runs a vector table, hand-written corner-case sequences, and then
// random traffic against a position-based reference model.
module tb_timer_dev;

  localparam logic [31:0] P_INIT = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:2]  Addr;
  logic        We;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  timer_dev #(.PRESET_INIT(P_INIT)) dut (
    .clk  (clk),
    .rst  (rst),
    .Addr (Addr),
    .We   (We),
    .DIn  (DIn),
    .DOut (DOut),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The timer is modelled by its position in a run.
  //   m_pos = -1 means the timer is idle.
  //   m_pos =  0 means the reload edge.
  //   m_pos =  1..m_len are the counting edges; COUNT reads m_len - m_pos.
  //   m_pos =  m_len+1 is the expiry edge.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  longint      m_pos;
  longint      m_len;

  function automatic void model_reset();
    m_ctrl   = 4'd0;
    m_preset = P_INIT;
    m_count  = 32'd0;
    m_flag   = 1'b0;
    m_pos    = -1;
    m_len    = 1;
  endfunction

  function automatic void model_edge(input logic [1:0] a, input logic w, input logic [31:0] d);
    logic        wr_c, wr_p, en, auto_m, expire;
    logic [3:0]  n_ctrl;
    logic [31:0] n_preset, n_count;
    logic        n_flag;
    longint      n_pos, n_len;
    wr_c   = w && (a == 2'd0);
    wr_p   = w && (a == 2'd1);
    en     = m_ctrl[0];
    auto_m = (m_ctrl[2:1] == 2'b01);
    expire = 1'b0;
    n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count;
    n_pos  = m_pos;  n_len = m_len;
    if (m_pos < 0) begin
      if (en) n_pos = 0;
    end else if (m_pos == 0) begin
      n_count = m_preset;
      n_len   = (m_preset == 32'd0) ? 1 : longint'(m_preset);
      n_pos   = 1;
    end else if (m_pos <= m_len) begin
      if (!en) n_pos = -1;
      else begin
        n_count = 32'(m_len - m_pos);
        n_pos   = m_pos + 1;
      end
    end else begin
      expire = 1'b1;
      n_pos  = -1;
    end
    if (wr_c || wr_p)          n_flag = 1'b0;
    else if (expire)           n_flag = 1'b1;
    else if (m_flag && auto_m) n_flag = 1'b0;
    else                       n_flag = m_flag;
    if (wr_c)                  n_ctrl = d[3:0];
    else if (expire && !auto_m) n_ctrl[0] = 1'b0;
    if (wr_p) n_preset = d;
    m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count;
    m_flag = n_flag; m_pos = n_pos; m_len = n_len;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // One clock cycle: drive on the falling edge, then compare just after the
  // rising edge against the model.
  task automatic step(input logic [1:0] a, input logic w, input logic [31:0] d);
    @(negedge clk);
    Addr = a; We = w; DIn = d;
    @(posedge clk);
    model_edge(a, w, d);
    #1;
    check("model_dout", DOut, model_read(a));
    check("model_irq", {31'd0, IRQ}, {31'd0, m_flag & m_ctrl[3]});
  endtask

  // While reset is held, read every register combinationally.
  task automatic check_reset_values(input string tag);
    We = 1'b0;
    for (int a = 0; a < 4; a++) begin
      Addr = 2'(a);
      #1;
      check($sformatf("%s_addr%0d", tag, a), DOut, (a == 1) ? P_INIT : 32'd0);
    end
    check({tag, "_irq"}, {31'd0, IRQ}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // One-shot run: PRESET=3, then CTRL=4'b1001 at edge 0.
    // After that, register-map and write-clear checks.
    tbl[0]  = '{2'd1, 1'b1, 32'd3,         32'd3, 1'b0};
    tbl[1]  = '{2'd0, 1'b1, 32'hFFFF_FFF9, 32'h9, 1'b0};
    tbl[2]  = '{2'd2, 1'b0, 32'd0,         32'd0, 1'b0};
    tbl[3]  = '{2'd2, 1'b0, 32'd0,         32'd3, 1'b0};
    tbl[4]  = '{2'd2, 1'b0, 32'd0,         32'd2, 1'b0};
    tbl[5]  = '{2'd2, 1'b0, 32'd0,         32'd1, 1'b0};
    tbl[6]  = '{2'd2, 1'b0, 32'd0,         32'd0, 1'b0};
    tbl[7]  = '{2'd0, 1'b0, 32'd0,         32'h8, 1'b1};
    tbl[8]  = '{2'd0, 1'b0, 32'd0,         32'h8, 1'b1};
    tbl[9]  = '{2'd3, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1};
    tbl[10] = '{2'd2, 1'b1, 32'h1234,      32'd0, 1'b1};
    tbl[11] = '{2'd0, 1'b1, 32'd0,         32'd0, 1'b0};
    tbl[12] = '{2'd1, 1'b0, 32'd0,         32'd3, 1'b0};

    // Power-on reset
    Addr = 2'd0; We = 1'b0; DIn = 32'd0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_reset_values("por");
    model_reset();
    @(negedge clk) rst = 1'b1;

    // The timer stays idle until software enables it
    for (int i = 0; i < 3; i++) step(2'd2, 1'b0, 32'd0);

    // Vector table
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].addr, tbl[i].we, tbl[i].din);
      check($sformatf("tbl%0d_dout", i), DOut, tbl[i].exp_dout);
      check($sformatf("tbl%0d_irq", i), {31'd0, IRQ}, {31'd0, tbl[i].exp_irq});
    end

    // Auto-reload, PRESET=2: one-cycle IRQ pulse every 5 edges, En stays set
    step(2'd1, 1'b1, 32'd2);
    step(2'd0, 1'b1, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      step(2'd0, 1'b0, 32'd0);
      check($sformatf("auto_irq_e%0d", k), {31'd0, IRQ}, (k % 5 == 0) ? 32'd1 : 32'd0);
      check("auto_ctrl", DOut, 32'hB);
    end
    step(2'd0, 1'b1, 32'd0);
    for (int i = 0; i < 3; i++) step(2'd2, 1'b0, 32'd0);

    // Masked one-shot expiry. A later CTRL write clears the hidden flag.
    step(2'd1, 1'b1, 32'd2);
    step(2'd0, 1'b1, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      step(2'd0, 1'b0, 32'd0);
      check("mask_irq", {31'd0, IRQ}, 32'd0);
    end
    check("mask_en_cleared", DOut, 32'd0);
    step(2'd0, 1'b1, 32'h8);
    check("mask_clear_irq", {31'd0, IRQ}, 32'd0);
    step(2'd0, 1'b0, 32'd0);
    check("mask_clear_irq2", {31'd0, IRQ}, 32'd0);

    // Pause at COUNT=5, then re-enable: COUNT reloads PRESET two edges later
    step(2'd1, 1'b1, 32'd10);
    step(2'd0, 1'b1, 32'h1);
    for (int k = 1; k <= 6; k++) step(2'd2, 1'b0, 32'd0);
    check("pause_pre", DOut, 32'd6);
    step(2'd0, 1'b1, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(2'd2, 1'b0, 32'd0);
      check("pause_hold", DOut, 32'd5);
    end
    step(2'd0, 1'b1, 32'h1);
    step(2'd2, 1'b0, 32'd0);
    check("resume_load_edge", DOut, 32'd5);
    step(2'd2, 1'b0, 32'd0);
    check("resume_reload", DOut, 32'd10);
    step(2'd0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) step(2'd2, 1'b0, 32'd0);

    // PRESET=0: IntFlag rises 4 edges after enable
    step(2'd1, 1'b1, 32'd0);
    step(2'd0, 1'b1, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      step(2'd0, 1'b0, 32'd0);
      check($sformatf("p0_irq_e%0d", k), {31'd0, IRQ}, (k == 4) ? 32'd1 : 32'd0);
    end
    step(2'd0, 1'b1, 32'h0);

    // PRESET=max: COUNT decrements with no wrap; a COUNT write is ignored
    step(2'd1, 1'b1, 32'hFFFF_FFFF);
    step(2'd0, 1'b1, 32'h1);
    step(2'd2, 1'b0, 32'd0);
    step(2'd2, 1'b0, 32'd0);
    check("max_load", DOut, 32'hFFFF_FFFF);
    step(2'd2, 1'b0, 32'd0);
    check("max_dec", DOut, 32'hFFFF_FFFE);
    step(2'd2, 1'b1, 32'd0);
    check("count_write_ignored", DOut, 32'hFFFF_FFFD);
    step(2'd0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) step(2'd2, 1'b0, 32'd0);

    // Asynchronous reset while IRQ=1
    step(2'd1, 1'b1, 32'd1);
    step(2'd0, 1'b1, 32'h9);
    for (int k = 1; k <= 4; k++) step(2'd0, 1'b0, 32'd0);
    check("pre_reset_irq", {31'd0, IRQ}, 32'd1);
    #1 rst = 1'b0;
    #1 check("async_irq_clear", {31'd0, IRQ}, 32'd0);
    check_reset_values("midrun");
    model_reset();
    @(negedge clk) rst = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  a;
      logic        w;
      logic [31:0] d;
      a = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 7) == 0);
      if (a == 2'd1) d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 9));
      else           d = $urandom;
      step(a, w, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
